product_bcd_formatter: RTL and testbench

//   Stage downstream of the product-sign register. Consumes the unsigned product magnitude from the

---
 rtl/mult_pkg.sv | 13 +
 rtl/product_bcd_formatter_if.sv | 30 +++
 rtl/bcd_add3_digit.sv | 10 +
 rtl/product_bcd_formatter.sv | 101 ++++++++++
 tb/tb_product_bcd_formatter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared sizing defaults and FSM state encoding for the product
// datapath and its BCD output formatter.
package mult_pkg;

   localparam int W      = 8;
   localparam int PROD_W = 2 * W;
   localparam int DIGITS = 5;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/product_bcd_formatter_if.sv
// Handshake and result bundle between the product-sign register
// stage and the BCD formatter.
interface product_bcd_formatter_if #(
   parameter int W      = mult_pkg::W,
   parameter int DIGITS = mult_pkg::DIGITS
);

   localparam int PROD_W = 2 * W;

   logic                start;
   logic [PROD_W-1:0]   magnitude;
   logic                negativeProductFlag;
   logic                busy;
   logic                done;
   logic [PROD_W:0]     signedProduct;
   logic                signOut;
   logic [4*DIGITS-1:0] bcd;
   logic [DIGITS-1:0]   digitValid;

   modport master (
      output start, magnitude, negativeProductFlag,
      input  busy, done, signedProduct, signOut, bcd, digitValid
   );

   modport slave (
      input  start, magnitude, negativeProductFlag,
      output busy, done, signedProduct, signOut, bcd, digitValid
   );

endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a digit of 5..9 becomes 8..12 so
// the following left shift carries into the next decimal digit.
module bcd_add3_digit (
   input  logic [3:0] d,
   output logic [3:0] q
);

   assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/product_bcd_formatter.sv
// Signed-product and sequential BCD formatter, one magnitude bit per clock.
// Build option: LEADING_ZERO_BLANK_EN masks leading zero digits.
module product_bcd_formatter
   import mult_pkg::*;
#(
   parameter int W      = 8,
   parameter int DIGITS = 5
) (
   input logic                    clk,
   input logic                    rst_n,
   product_bcd_formatter_if.slave bus
);

   localparam int PROD_W = 2 * W;
   localparam int BCD_W  = 4 * DIGITS;
   localparam int CNT_W  = $clog2(PROD_W + 1);

   logic [1:0]        state;
   logic [PROD_W-1:0] shift_reg;
   logic [BCD_W-1:0]  acc;
   logic [BCD_W-1:0]  acc_fix;
   logic [CNT_W-1:0]  bit_count;
   logic [DIGITS-1:0] valid_mask;

   for (genvar g = 0; g < DIGITS; g++) begin : g_fix
      bcd_add3_digit u_fix (
         .d (acc[4*g +: 4]),
         .q (acc_fix[4*g +: 4])
      );
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic seen;

   // Scan from the top digit down; digit 0 stays lit so zero shows "0".
   always_comb begin
      seen       = 1'b0;
      valid_mask = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen          = seen | (acc[4*i +: 4] != 4'd0);
         valid_mask[i] = seen | (i == 0);
      end
   end
`else
   always_comb begin
      valid_mask = '1;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         shift_reg         <= '0;
         acc               <= '0;
         bit_count         <= '0;
         bus.busy          <= 1'b0;
         bus.done          <= 1'b0;
         bus.signedProduct <= '0;
         bus.signOut       <= 1'b0;
         bus.bcd           <= '0;
         bus.digitValid    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  shift_reg <= bus.magnitude;
                  acc       <= '0;
                  bit_count <= CNT_W'(PROD_W);
                  // Extra top bit keeps full-scale magnitudes from overflowing.
                  bus.signedProduct <= bus.negativeProductFlag
                                     ? -{1'b0, bus.magnitude}
                                     : {1'b0, bus.magnitude};
                  bus.signOut <= bus.negativeProductFlag
                               & (|bus.magnitude);
                  bus.busy    <= 1'b1;
                  state       <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               {acc, shift_reg} <= {acc_fix, shift_reg} << 1;
               bit_count        <= bit_count - 1'b1;
               if (bit_count == CNT_W'(1)) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               bus.bcd        <= acc;
               bus.digitValid <= valid_mask;
               bus.done       <= 1'b1;
               bus.busy       <= 1'b0;
               state          <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_product_bcd_formatter.sv
// Self-checking bench for product_bcd_formatter against a decimal
// arithmetic reference model (W=8, PROD_W=16, DIGITS=5).
module tb_product_bcd_formatter;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   product_bcd_formatter_if bus ();

   product_bcd_formatter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int errors  = 0;

   localparam int LAT = 17;

   function automatic logic [19:0] ref_bcd(input int v);
      logic [19:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [4:0] ref_mask(input int v);
`ifdef LEADING_ZERO_BLANK_EN
      int n;
      int t;
      n = 1;
      t = v / 10;
      while (t > 0) begin
         n++;
         t = t / 10;
      end
      return 5'((1 << n) - 1);
`else
      return 5'b11111 | 5'(v & 0);
`endif
   endfunction

   function automatic logic [16:0] ref_signed(input int v, input bit f);
      int s;
      s = f ? -v : v;
      return 17'(s);
   endfunction

   task automatic pulse_start(input int mag, input bit f);
      @(negedge clk);
      bus.start               = 1'b1;
      bus.magnitude           = 16'(mag);
      bus.negativeProductFlag = f;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output bit seen);
      seen = 1'b0;
      lat  = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat  = c;
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.magnitude = '0;
      bus.negativeProductFlag = 1'b0;
      repeat (3) @(negedge clk);
      vectors += 6;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
      end
      if (bus.done !== 1'b0) begin
         errors++; $display("FAIL reset_done got=%b exp=0", bus.done);
      end
      if (bus.signedProduct !== 17'h0) begin
         errors++; $display("FAIL reset_sp got=%h exp=0", bus.signedProduct);
      end
      if (bus.signOut !== 1'b0) begin
         errors++; $display("FAIL reset_sign got=%b exp=0", bus.signOut);
      end
      if (bus.bcd !== 20'h0) begin
         errors++; $display("FAIL reset_bcd got=%h exp=0", bus.bcd);
      end
      if (bus.digitValid !== 5'h0) begin
         errors++; $display("FAIL reset_dv got=%b exp=0", bus.digitValid);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_convert(input string name, input int mag,
                               input bit f);
      int lat;
      bit seen;
      pulse_start(mag, f);
      vectors++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL %s_busy got=%b exp=1", name, bus.busy);
      end
      wait_done(lat, seen);
      vectors++;
      if (!seen) begin
         errors++; $display("FAIL %s_timeout no done in 40 cycles", name);
         return;
      end
      vectors += 6;
      if (lat !== LAT) begin
         errors++; $display("FAIL %s_lat got=%0d exp=%0d", name, lat, LAT);
      end
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL %s_busy_done got=%b exp=0", name, bus.busy);
      end
      if (bus.signedProduct !== ref_signed(mag, f)) begin
         errors++;
         $display("FAIL %s_sp got=%h exp=%h", name,
                  bus.signedProduct, ref_signed(mag, f));
      end
      if (bus.signOut !== (f && mag != 0)) begin
         errors++;
         $display("FAIL %s_sign got=%b exp=%b", name, bus.signOut,
                  (f && mag != 0));
      end
      if (bus.bcd !== ref_bcd(mag)) begin
         errors++;
         $display("FAIL %s_bcd got=%h exp=%h", name, bus.bcd, ref_bcd(mag));
      end
      if (bus.digitValid !== ref_mask(mag)) begin
         errors++;
         $display("FAIL %s_dv got=%b exp=%b", name,
                  bus.digitValid, ref_mask(mag));
      end
      @(negedge clk);
      vectors += 2;
      if (bus.done !== 1'b0) begin
         errors++; $display("FAIL %s_pulse got=%b exp=0", name, bus.done);
      end
      if (bus.bcd !== ref_bcd(mag)) begin
         errors++;
         $display("FAIL %s_hold got=%h exp=%h", name, bus.bcd, ref_bcd(mag));
      end
   endtask

   task automatic test_directed();
      test_convert("neg16384", 16384, 1'b1);
      test_convert("max", 65535, 1'b0);
      test_convert("negzero", 0, 1'b1);
      test_convert("one", 1, 1'b0);
   endtask

   task automatic test_ignore_start();
      int ndone;
      int first;
      pulse_start(42, 1'b0);
      repeat (2) @(negedge clk);
      bus.start     = 1'b1;
      bus.magnitude = 16'd7;
      @(negedge clk);
      bus.start = 1'b0;
      ndone = 0;
      first = 0;
      for (int c = 4; c <= 45; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ndone++;
            if (first == 0) first = c;
         end
      end
      vectors += 4;
      if (ndone !== 1) begin
         errors++; $display("FAIL ign_pulses got=%0d exp=1", ndone);
      end
      if (first !== LAT) begin
         errors++; $display("FAIL ign_lat got=%0d exp=%0d", first, LAT);
      end
      if (bus.bcd !== 20'h00042) begin
         errors++; $display("FAIL ign_bcd got=%h exp=00042", bus.bcd);
      end
      if (bus.digitValid !== ref_mask(42)) begin
         errors++;
         $display("FAIL ign_dv got=%b exp=%b", bus.digitValid, ref_mask(42));
      end
   endtask

   task automatic test_reset_abort();
      pulse_start(999, 1'b1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      vectors += 6;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy);
      end
      if (bus.done !== 1'b0) begin
         errors++; $display("FAIL abort_done got=%b exp=0", bus.done);
      end
      if (bus.signedProduct !== 17'h0) begin
         errors++; $display("FAIL abort_sp got=%h exp=0", bus.signedProduct);
      end
      if (bus.signOut !== 1'b0) begin
         errors++; $display("FAIL abort_sign got=%b exp=0", bus.signOut);
      end
      if (bus.bcd !== 20'h0) begin
         errors++; $display("FAIL abort_bcd got=%h exp=0", bus.bcd);
      end
      if (bus.digitValid !== 5'h0) begin
         errors++; $display("FAIL abort_dv got=%b exp=0", bus.digitValid);
      end
      // A start pulse coinciding with reset must not be accepted.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL rst_start_busy got=%b exp=0", bus.busy);
      end
      test_convert("after_abort", 999, 1'b0);
   endtask

   task automatic test_back_to_back();
      int lat;
      bit seen;
      pulse_start(5, 1'b0);
      wait_done(lat, seen);
      vectors++;
      if (!seen) begin
         errors++; $display("FAIL b2b_first_timeout no done");
         return;
      end
      bus.start               = 1'b1;
      bus.magnitude           = 16'd100;
      bus.negativeProductFlag = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat, seen);
      vectors++;
      if (!seen) begin
         errors++; $display("FAIL b2b_timeout no done");
         return;
      end
      vectors += 4;
      if (lat !== LAT) begin
         errors++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, LAT);
      end
      if (bus.signedProduct !== 17'h1FF9C) begin
         errors++; $display("FAIL b2b_sp got=%h exp=1ff9c", bus.signedProduct);
      end
      if (bus.signOut !== 1'b1) begin
         errors++; $display("FAIL b2b_sign got=%b exp=1", bus.signOut);
      end
      if (bus.bcd !== 20'h00100) begin
         errors++; $display("FAIL b2b_bcd got=%h exp=00100", bus.bcd);
      end
   endtask

   task automatic test_random();
      int mag;
      bit f;
      for (int i = 0; i < 24; i++) begin
         unique case (i % 4)
            0:       mag = int'($urandom_range(0, 9));
            1:       mag = int'($urandom_range(10, 999));
            default: mag = int'($urandom_range(0, 65535));
         endcase
         f = 1'($urandom);
         test_convert($sformatf("rnd%0d", i), mag, f);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
